// File: rtl/fpga_link_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// fpga_link_rx_fifo_if
// Bundles the serial link handshake and the consumer-side FIFO signals of
// fpga_link_rx_fifo.
//   send, finish, data_line : link transmitter -> receiver
//   acknowledge             : receiver -> link transmitter
//   processed               : consumer pop strobe
//   data_out, received      : FIFO head byte and not-empty flag
//   frame_error             : one-cycle protocol-violation pulse
//   fifo_count              : FIFO occupancy, 0..FIFO_DEPTH
// master = transmitter/consumer side, slave = receiver (the FIFO block).
// -----------------------------------------------------------------------------
interface fpga_link_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          send;
    logic          finish;
    logic          data_line;
    logic          processed;
    logic          acknowledge;
    logic [7:0]    data_out;
    logic          received;
    logic          frame_error;
    logic [CW-1:0] fifo_count;

    modport master (
        output send, finish, data_line, processed,
        input  acknowledge, data_out, received, frame_error, fifo_count
    );

    modport slave (
        input  send, finish, data_line, processed,
        output acknowledge, data_out, received, frame_error, fifo_count
    );
endinterface

// File: rtl/fpga_link_rx_fifo.sv
// -----------------------------------------------------------------------------
// fpga_link_rx_fifo
// Receives bytes over a one-bit serial link (LSB first while send=1), then
// completes a four-phase finish/acknowledge handshake and pushes the byte into
// a circular FIFO read by a consumer through processed/data_out.
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-low
//   link  : fpga_link_rx_fifo_if.slave (handshake, serial data, FIFO outputs)
// -----------------------------------------------------------------------------
module fpga_link_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fpga_link_rx_fifo_if.slave    link
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_WAIT_FIN = 2'd2;
    localparam logic [1:0] ST_ACK      = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          ack_q,     ack_d;
    logic          ferr_q,    ferr_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0] count_q,   count_d;

    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          push;
    logic          pop;
    logic          space;

    always_comb begin
        // A pop with an empty FIFO is simply ignored.
        pop   = link.processed && (count_q != '0);
        // A full FIFO still has room if the head leaves in the same cycle.
        space = (count_q != CW'(FIFO_DEPTH)) || pop;

        push      = 1'b0;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_d     = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // finish is deliberately ignored here.
                if (link.send) begin
                    shift_d   = {7'd0, link.data_line};
                    bit_cnt_d = 3'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (link.send) begin
                    shift_d[bit_cnt_q] = link.data_line;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WAIT_FIN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    // Truncated byte: report and drop it.
                    ferr_d    = 1'b1;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_FIN: begin
                if (link.finish) begin
                    // Without space the byte is held here until the consumer
                    // frees an entry; acknowledge stays low meanwhile.
                    if (space) begin
                        push    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end else if (link.send) begin
                    // A new byte started before the handshake finished.
                    ferr_d  = 1'b1;
                    shift_d = 8'h00;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (link.finish) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Power-of-two depth: pointers wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            ack_q     <= 1'b0;
            ferr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            ferr_q    <= ferr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage has no reset; entries are only observed while counted valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= shift_q;
        end
    end

    assign link.acknowledge = ack_q;
    assign link.frame_error = ferr_q;
    assign link.fifo_count  = count_q;
    assign link.received    = (count_q != '0);
    // Forced to zero when empty so reset and idle read as 8'h00.
    assign link.data_out    = (count_q != '0) ? fifo_mem[rd_ptr_q] : 8'h00;

endmodule

// File: doc/fpga_link_rx_fifo.md
FPGA_LINK_RX_FIFO -- requirements
Module: fpga_link_rx_fifo

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, received-byte buffer depth; SHALL be a power of two, minimum 2.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clock.
REQ-004 Port: send  input  1  from link transmitter; high while the 8 data bits are presented.
REQ-005 Port: finish  input  1  from link transmitter; frame-complete request, held high until acknowledge is seen.
REQ-006 Port: data_line  input  1  serial data, one bit per clock while send=1, LSB first.
REQ-007 Port: processed  input  1  consumer pop strobe; one byte popped per cycle while high and received=1.
REQ-008 Port: acknowledge  output  1  to link transmitter; byte accepted.
REQ-009 Port: data_out  output  8  byte at the FIFO head; valid when received=1.
REQ-010 Port: received  output  1  FIFO not empty.
REQ-011 Port: frame_error  output  1  one-cycle pulse on protocol violation.
REQ-012 Port: fifo_count  output  log2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, WAIT_FIN and ACK.
REQ-014 IDLE: on send=1, sample data_line as bit 0, set bit count to 1, go to SHIFT; finish=1 in IDLE SHALL be ignored.
REQ-015 SHIFT: on send=1, sample data_line into bit[count] and increment count; on the cycle the 8th bit is sampled, go to WAIT_FIN.
REQ-016 SHIFT: send=0 before 8 bits are sampled SHALL pulse frame_error, discard the partial byte and return to IDLE.
REQ-017 WAIT_FIN: send=1 with finish=0 SHALL pulse frame_error, discard the byte and return to IDLE.
REQ-018 WAIT_FIN: on finish=1 with space available, push the assembled byte and go to ACK on the next edge.
REQ-019 Space is available when fifo_count < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
REQ-020 WAIT_FIN, FIFO full and no same-cycle pop: hold the byte, keep acknowledge=0 and stall until space exists. No byte SHALL be dropped.
REQ-021 ACK: acknowledge=1 (registered) while finish=1; on finish=0, deassert acknowledge and return to IDLE. This completes the four-phase handshake.
REQ-022 acknowledge SHALL be 0 in every state other than ACK.
REQ-023 Minimum frame latency: last data bit to acknowledge=1 is 2 cycles when finish rises on the cycle after the last bit.
REQ-024 FIFO: circular buffer with write/read pointers wrapping modulo FIFO_DEPTH.
REQ-025 data_out SHALL equal the head entry combinationally from registered state.
REQ-026 processed with received=0 SHALL be ignored.
REQ-027 Same-cycle push and pop SHALL leave fifo_count unchanged and preserve byte order.
REQ-028 Bytes SHALL emerge in arrival order; a byte is visible on data_out the cycle after its push.
REQ-029 frame_error SHALL be a single-cycle pulse and SHALL NOT alter FIFO contents.

Reset
REQ-030 reset=0 SHALL asynchronously force state=IDLE, bit count=0, pointers=0, fifo_count=0, acknowledge=0, received=0, frame_error=0, data_out=8'h00.
REQ-031 reset asserted mid-frame or mid-handshake SHALL discard the partial byte and all buffered bytes; after release the FSM resumes in IDLE and waits for send.
REQ-032 On reset release, the first rising edge SHALL process normally; no spurious acknowledge or frame_error.

Verification
REQ-033 Send 0xA5 LSB first, then finish -> acknowledge rises 2 cycles after the last bit and falls the cycle after finish drops; received=1, data_out=0xA5, fifo_count=1.
REQ-034 Send 5 bytes 0x01..0x05 with processed=0 (FIFO_DEPTH=4) -> 4 acknowledged; the 5th stalls with acknowledge=0; pulse processed once -> the 5th is accepted; pops yield 0x02..0x05.
REQ-035 Drop send after 3 bits -> one-cycle frame_error, fifo_count unchanged, next full frame received correctly.
REQ-036 FIFO full, finish=1 and processed=1 in the same cycle -> push and pop both occur, fifo_count stays 4, order preserved.
REQ-037 Assert reset during ACK with 2 bytes buffered -> acknowledge=0 and received=0 immediately, fifo_count=0; the next frame is received normally.
REQ-038 processed pulsed while empty -> no change; 6 push/pop cycles across pointer wrap -> data intact.
